multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter CH, default 4, number of independent button channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of debounce and hold counters.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 btn  input  CH  raw asynchronous button levels, one bit per channel.
REQ-007 thresh  input  CNT_W  debounce threshold in cycles, shared by all channels; quasi-static.
REQ-008 hold_thresh  input  CNT_W  long-press threshold in cycles; quasi-static.
REQ-009 btn_out  output  CH  debounced level per channel.
REQ-010 rise  output  CH  one-cycle pulse when btn_out goes 0->1.
REQ-011 fall  output  CH  one-cycle pulse when btn_out goes 1->0.
REQ-012 hold  output  CH  one-cycle pulse when a press has lasted hold_thresh cycles.

Function
REQ-013 Each channel SHALL pass btn[i] through SYNC_STAGES flops; s[i] denotes the last stage.
REQ-014 Channels SHALL be fully independent; activity on one SHALL NOT affect another.
REQ-015 If s[i]==btn_out[i], the debounce counter SHALL clear to 0 that cycle.
REQ-016 If s[i]!=btn_out[i], the counter SHALL increment; when it reaches eff_thresh-1, btn_out[i] SHALL take s[i] next edge and the counter SHALL clear.
REQ-017 eff_thresh = max(thresh,1); btn_out[i] SHALL change only after s[i] differs for exactly eff_thresh consecutive cycles.
REQ-018 A single-cycle return of s[i] to btn_out[i] SHALL restart the count from 0 (no partial credit).
REQ-019 Pin-to-btn_out latency SHALL be SYNC_STAGES+eff_thresh cycles for a clean step.
REQ-020 rise[i]/fall[i] SHALL assert in the same cycle btn_out[i] shows the new value, for exactly one cycle.
REQ-021 The hold counter SHALL clear while btn_out[i]==0 and increment while btn_out[i]==1, saturating at all-ones.
REQ-022 hold[i] SHALL pulse one cycle when the hold counter equals max(hold_thresh,1)-1, at most once per press.
REQ-023 hold_thresh==0 SHALL be treated as 1; hold then pulses one cycle after rise.
REQ-024 Counters SHALL never wrap; the debounce counter is bounded by eff_thresh and needs no saturation.
REQ-025 Changes to thresh/hold_thresh mid-count SHALL take effect on the next comparison; no glitch pulses beyond REQ-020/022.

Reset
REQ-026 While rst==0, synchronisers, counters, btn_out, rise, fall and hold SHALL all be 0, independent of clk.
REQ-027 Reset deassertion SHALL be synchronised externally; after release, a held-high button produces rise after SYNC_STAGES+eff_thresh cycles.
REQ-028 Reset asserted mid-count or mid-press SHALL discard progress; no rise/fall/hold pulse SHALL be emitted for it.

Structure
REQ-029 Package multi_debounce_pkg SHALL hold default values of CH, CNT_W, SYNC_STAGES and the eff-threshold helper function.
REQ-030 One sub-module debounce_ch (synchroniser, debounce counter, hold counter, pulses for one channel) SHALL be instantiated CH times by a generate loop.
REQ-031 Top level SHALL contain no logic beyond instantiation and bus concatenation.

Verification
REQ-032 thresh=5, btn[0] clean 0->1 -> btn_out[0]=1 and rise[0]=1 exactly 7 cycles after the edge (SYNC_STAGES=2), rise width 1.
REQ-033 thresh=5, btn[1] bounces 1,0,1,1,0 then steady 1 -> single rise[1] 7 cycles after final steady edge, no fall.
REQ-034 thresh=4, hold_thresh=20, btn[2] held 40 cycles -> rise, one hold pulse 20 cycles after rise, fall 6 cycles after release.
REQ-035 thresh=0 -> acts as 1: btn_out follows s with one extra cycle; hold_thresh=0 -> hold one cycle after rise.
REQ-036 rst pulled low 3 cycles into a 10-cycle count, released -> all outputs 0 asynchronously, no pulse; full count restarts.
REQ-037 CH=8, all channels toggled at staggered times -> per-channel outputs match a reference model; no cross-channel coupling.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// Shared defaults and the threshold helper for the multi-channel button debouncer.
package multi_debounce_pkg;

  localparam int DEF_CH          = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int MAX_CNT_W       = 32;

  // Compare value for a threshold: the counter's value on the last counted cycle, with 0 treated as 1.
  function automatic logic [MAX_CNT_W-1:0] eff_limit(input logic [MAX_CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: synchroniser, debounce counter, long-press counter and edge/hold pulses.
module debounce_ch
  import multi_debounce_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [CNT_W-1:0] thresh,
  input  logic [CNT_W-1:0] hold_thresh,
  output logic             btn_out,
  output logic             rise,
  output logic             fall,
  output logic             hold
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hcnt;
  logic                   r_btn_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_hold;
  logic                   r_held;

  logic                   w_s;
  logic [CNT_W-1:0]       w_deb_lim;
  logic [CNT_W-1:0]       w_hold_lim;
  logic                   w_deb_hit;
  logic                   w_hold_hit;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_deb_lim  = CNT_W'(eff_limit(MAX_CNT_W'(thresh)));
  assign w_hold_lim = CNT_W'(eff_limit(MAX_CNT_W'(hold_thresh)));
  // >= rather than == so a threshold lowered mid-count still terminates instead of wrapping.
  assign w_deb_hit  = (w_s != r_btn_out) && (r_cnt >= w_deb_lim);
  assign w_hold_hit = r_btn_out && !r_held && (r_hcnt == w_hold_lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_btn_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_btn_out) begin
        r_cnt <= '0;
      end else if (w_deb_hit) begin
        r_cnt     <= '0;
        r_btn_out <= w_s;
        r_rise    <= w_s;
        r_fall    <= !w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_held <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      r_hold <= w_hold_hit;
      if (!r_btn_out) begin
        r_hcnt <= '0;
        r_held <= 1'b0;
      end else begin
        if (r_hcnt != '1) r_hcnt <= r_hcnt + 1'b1;
        if (w_hold_hit)   r_held <= 1'b1;
      end
    end
  end

  assign btn_out = r_btn_out;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign hold    = r_hold;

endmodule

// File: rtl/multi_debounce.sv
// CH independent debounce channels sharing one clock, reset and threshold pair.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int CH          = DEF_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    btn,
  input  logic [CNT_W-1:0] thresh,
  input  logic [CNT_W-1:0] hold_thresh,
  output logic [CH-1:0]    btn_out,
  output logic [CH-1:0]    rise,
  output logic [CH-1:0]    fall,
  output logic [CH-1:0]    hold
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    debounce_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn[g]),
      .thresh      (thresh),
      .hold_thresh (hold_thresh),
      .btn_out     (btn_out[g]),
      .rise        (rise[g]),
      .fall        (fall[g]),
      .hold        (hold[g])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with 8 channels, 2 sync stages and hand-derived edge timing.
module tb_multi_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  btn;
  logic [15:0] thresh;
  logic [15:0] hold_thresh;
  logic [7:0]  btn_out;
  logic [7:0]  rise;
  logic [7:0]  fall;
  logic [7:0]  hold;

  int n_cmp = 0;
  int n_err = 0;

  multi_debounce #(
    .CH          (8),
    .CNT_W       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .thresh      (thresh),
    .hold_thresh (hold_thresh),
    .btn_out     (btn_out),
    .rise        (rise),
    .fall        (fall),
    .hold        (hold)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn = '0; thresh = 16'd1; hold_thresh = 16'd1000;
    repeat (8) tick();
    n_cmp++;
    if ({btn_out, rise, fall, hold} !== 32'h0) begin
      n_err++;
      $display("FAIL settle got=%h exp=%h", {btn_out, rise, fall, hold}, 32'h0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '0; thresh = 16'd5; hold_thresh = 16'd1000;
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({btn_out, rise, fall, hold} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=%h", {btn_out, rise, fall, hold}, 32'h0);
    end
    btn = 8'hFF;
    repeat (4) tick();
    n_cmp++;
    if ({btn_out, rise, fall, hold} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_held got=%h exp=%h", {btn_out, rise, fall, hold}, 32'h0);
    end
    btn = '0;
    rst = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if ({btn_out, rise, fall, hold} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release got=%h exp=%h", {btn_out, rise, fall, hold}, 32'h0);
    end
  endtask

  task automatic test_clean_step();
    logic [7:0] eo, er, ef;
    thresh = 16'd5; hold_thresh = 16'd1000;
    btn[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      eo = (k >= 7) ? 8'h01 : 8'h00;
      er = (k == 7) ? 8'h01 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, er, 8'h00, 8'h00}) begin
        n_err++;
        $display("FAIL clean_rise k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, er, 8'h00, 8'h00});
      end
    end
    btn[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      eo = (k < 7) ? 8'h01 : 8'h00;
      ef = (k == 7) ? 8'h01 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, 8'h00, ef, 8'h00}) begin
        n_err++;
        $display("FAIL clean_fall k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, 8'h00, ef, 8'h00});
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic [7:0] eo, er;
    pat = 5'b01101;
    thresh = 16'd5; hold_thresh = 16'd1000;
    for (int j = 0; j < 5; j++) begin
      btn[1] = pat[j];
      tick();
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== 32'h0) begin
        n_err++;
        $display("FAIL bounce_quiet j=%0d got=%h exp=%h", j, {btn_out, rise, fall, hold}, 32'h0);
      end
    end
    btn[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      eo = (k >= 7) ? 8'h02 : 8'h00;
      er = (k == 7) ? 8'h02 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, er, 8'h00, 8'h00}) begin
        n_err++;
        $display("FAIL bounce_rise k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, er, 8'h00, 8'h00});
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] eo, er, ef, eh;
    thresh = 16'd4; hold_thresh = 16'd20;
    btn[2] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      eo = (k >= 6)  ? 8'h04 : 8'h00;
      er = (k == 6)  ? 8'h04 : 8'h00;
      eh = (k == 26) ? 8'h04 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, er, 8'h00, eh}) begin
        n_err++;
        $display("FAIL hold_press k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, er, 8'h00, eh});
      end
    end
    btn[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      eo = (k < 6)  ? 8'h04 : 8'h00;
      ef = (k == 6) ? 8'h04 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, 8'h00, ef, 8'h00}) begin
        n_err++;
        $display("FAIL hold_release k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, 8'h00, ef, 8'h00});
      end
    end
  endtask

  task automatic test_zero_thresh();
    logic [7:0] eo, er, ef, eh;
    thresh = 16'd0; hold_thresh = 16'd0;
    btn[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      eo = (k >= 3) ? 8'h08 : 8'h00;
      er = (k == 3) ? 8'h08 : 8'h00;
      eh = (k == 4) ? 8'h08 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, er, 8'h00, eh}) begin
        n_err++;
        $display("FAIL zero_press k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, er, 8'h00, eh});
      end
    end
    btn[3] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      eo = (k < 3)  ? 8'h08 : 8'h00;
      ef = (k == 3) ? 8'h08 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, 8'h00, ef, 8'h00}) begin
        n_err++;
        $display("FAIL zero_release k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, 8'h00, ef, 8'h00});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] eo, er;
    thresh = 16'd10; hold_thresh = 16'd1000;
    btn[5] = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if ({btn_out, rise, fall, hold} !== {8'h20, 8'h20, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL rstmid_pre got=%h exp=%h", {btn_out, rise, fall, hold}, {8'h20, 8'h20, 8'h00, 8'h00});
    end
    btn[4] = 1'b1;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({btn_out, rise, fall, hold} !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_async got=%h exp=%h", {btn_out, rise, fall, hold}, 32'h0);
    end
    repeat (3) tick();
    n_cmp++;
    if ({btn_out, rise, fall, hold} !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_held got=%h exp=%h", {btn_out, rise, fall, hold}, 32'h0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      eo = (k >= 12) ? 8'h30 : 8'h00;
      er = (k == 12) ? 8'h30 : 8'h00;
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, er, 8'h00, 8'h00}) begin
        n_err++;
        $display("FAIL rstmid_restart k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, er, 8'h00, 8'h00});
      end
    end
  endtask

  // Channel i presses at step 2i+1 and releases at step 2i+20; with thresh=3 each edge shows 4 steps later.
  task automatic test_stagger();
    logic [7:0] eo, er, ef;
    thresh = 16'd3; hold_thresh = 16'd1000;
    for (int k = 0; k <= 45; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (k == 2*i + 1)  btn[i] = 1'b1;
        if (k == 2*i + 20) btn[i] = 1'b0;
      end
      tick();
      for (int i = 0; i < 8; i++) begin
        eo[i] = (k >= 2*i + 5) && (k < 2*i + 24);
        er[i] = (k == 2*i + 5);
        ef[i] = (k == 2*i + 24);
      end
      n_cmp++;
      if ({btn_out, rise, fall, hold} !== {eo, er, ef, 8'h00}) begin
        n_err++;
        $display("FAIL stagger k=%0d got=%h exp=%h", k, {btn_out, rise, fall, hold}, {eo, er, ef, 8'h00});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    settle();
    test_bounce();
    settle();
    test_hold();
    settle();
    test_zero_thresh();
    settle();
    test_reset_mid();
    settle();
    test_stagger();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
